alu_share_arb: RTL

- Two-requester round-robin arbiter and sequencer for the single shared 16-bit ALU (3-bit opcode: ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB).
- Latches the winning requester's operands and opcode, drives them to the combinational ALU for one cycle, and registers the result and Z/V/N flags.
- Returns the result to the granted requester with a one-cycle done pulse.
- Sits between the execute-stage issue logic (requester 0) and the auxiliary vector/reduction unit (requester 1).

---
 rtl/alu_share_arb_if.sv | 35 +++
 rtl/alu_share_arb.sv | 101 ++++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
// Requester, result and ALU-side signals of the shared-ALU arbiter.
// master = requesters plus the external ALU; slave = the arbiter itself.
interface alu_share_arb_if;
  logic        req0;
  logic [2:0]  op0;
  logic [15:0] a0;
  logic [15:0] b0;
  logic        req1;
  logic [2:0]  op1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] result;
  logic [2:0]  flags;
  logic        busy;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_out;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    input  gnt0, gnt1, done0, done1, result, flags, busy,
           alu_in1, alu_in2, alu_opcode
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    output gnt0, gnt1, done0, done1, result, flags, busy,
           alu_in1, alu_in2, alu_opcode
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer for one shared 16-bit ALU: IDLE -> EXEC -> RESP.
// Grant one cycle after the sampling edge, done the cycle after; requests held by requesters.
module alu_share_arb #(
  parameter logic RR_INIT = 1'b0
) (
  input logic      clk,
  input logic      rst_n,
  alu_share_arb_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  state_t      state, nxt;
  logic        take;
  logic        pick;
  logic        owner;
  logic        last_gnt;
  logic [15:0] in1, in2;
  logic [2:0]  opc;
  logic [15:0] res;
  logic [2:0]  flg;
  logic [15:0] sum, diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    take = 1'b0;
    pick = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          take = 1'b1;
          // Contention goes to whoever was not served last; a lone requester always wins.
          pick = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
          nxt  = EXEC;
        end
      end
      EXEC:    nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= 1'b0;
      last_gnt <= ~RR_INIT;
      in1      <= '0;
      in2      <= '0;
      opc      <= OP_ADD;
    end else if (take) begin
      owner    <= pick;
      last_gnt <= pick;
      in1      <= pick ? bus.a1  : bus.a0;
      in2      <= pick ? bus.b1  : bus.b0;
      opc      <= pick ? bus.op1 : bus.op0;
    end
  end

  assign sum  = in1 + in2;
  assign diff = in1 - in2;

  // flg = {Z,V,N}; V and N only move on ADD/SUB and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      flg <= '0;
    end else if (state == EXEC) begin
      res    <= bus.alu_out;
      flg[2] <= (bus.alu_out == 16'h0000);
      if (opc == OP_ADD) begin
        flg[1] <= (in1[15] == in2[15]) && (sum[15] != in1[15]);
        flg[0] <= bus.alu_out[15];
      end else if (opc == OP_SUB) begin
        flg[1] <= (in1[15] != in2[15]) && (diff[15] != in1[15]);
        flg[0] <= bus.alu_out[15];
      end
    end
  end

  assign bus.gnt0       = (state == EXEC) && !owner;
  assign bus.gnt1       = (state == EXEC) &&  owner;
  assign bus.done0      = (state == RESP) && !owner;
  assign bus.done1      = (state == RESP) &&  owner;
  assign bus.busy       = (state != IDLE);
  assign bus.result     = res;
  assign bus.flags      = flg;
  assign bus.alu_in1    = in1;
  assign bus.alu_in2    = in2;
  assign bus.alu_opcode = opc;
endmodule
